stopwatch_timebase: RTL
=======================

// Module: stopwatch_timebase
// PURPOSE
//  Parametrised MM:SS stopwatch core with run, pause and adjust modes.
//  Counts on an external 1 Hz strobe and adjusts the selected field on an external adjust-rate strobe.
//  Sits between the clock-divider/debounce front end and the 7-segment display driver.
//  Adjust increments one field modulo its range, with no carry into the other field.
// PARAMETERS
//  SEC_MOD   60  seconds modulus; seconds count 0..SEC_MOD-1
//  MIN_MOD   60  minutes modulus; minutes count 0..MIN_MOD-1
//  ADJ_STEP  1   adjust increment per adj_tick; legal range 1..min(SEC_MOD,MIN_MOD)-1
//  localparams: SEC_W=$clog2(SEC_MOD), MIN_W=$clog2(MIN_MOD)
// PORTS
//  clk       in   1      system clock; one clock domain only
//  rst_n     in   1      asynchronous, active-low reset
//  tick      in   1      1-cycle count strobe (1 Hz)
//  adj_tick  in   1      1-cycle adjust strobe (e.g. 2 Hz)
//  adj       in   1      level; 1 = adjust mode
//  sel       in   1      level; 1 = adjust seconds, 0 = adjust minutes
//  pse       in   1      debounced 1-cycle pulse; toggles pause
//  clr       in   1      debounced 1-cycle pulse; synchronous clear to 00:00
//  sec       out  SEC_W  seconds value
//  min       out  MIN_W  minutes value
//  paused    out  1      pause flag
//  wrap      out  1      1-cycle pulse when a run tick rolls MM:SS from max to 00:00
// BEHAVIOUR
//  Reset (rst_n=0, async): sec=0, min=0, paused=0, wrap=0, state=ST_RUN.
//  All outputs are registered. A strobe sampled at edge n is visible after edge n (latency 1).
//  FSM states:
//   ST_RUN:   tick advances the count. adj=1 -> ST_ADJ. pse -> ST_PAUSE (paused=1).
//   ST_PAUSE: tick ignored. adj=1 -> ST_ADJ. pse -> ST_RUN (paused=0).
//   ST_ADJ:   tick ignored. adj_tick adds ADJ_STEP to the sel field, modulo its range.
//             pse toggles paused only. adj=0 -> ST_PAUSE if paused, else ST_RUN.
//  Priority within one edge: clr > pse > adjust > tick.
//   clr: sec=min=0, wrap=0; state and paused unchanged.
//   pse + tick in ST_RUN: tick is dropped and the count holds.
//   tick + adj_tick in ST_ADJ: only the adjust acts.
//  Run count: sec at SEC_MOD-1 -> sec=0, min+1. min at MIN_MOD-1 with a sec carry -> min=0, wrap=1.
//  Adjust arithmetic: v' = (v+ADJ_STEP >= MOD) ? v+ADJ_STEP-MOD : v+ADJ_STEP.
//   Adjust produces no inter-field carry and no wrap pulse.
//  sel may change at any time; it is sampled on the adj_tick edge.
//  adj asserted mid-second: the partial second is discarded; counting resumes on the next tick after exit.
//  Outputs never leave the range 0..MOD-1, including with ADJ_STEP>1.
// CONFIGURATION
//  Macro STOPWATCH_COUNTDOWN_EN:
//   Defined: adds input down (1 bit) and output done (1 bit).
//    down=1: a run tick decrements; 00:01 -> 00:00; 01:00 -> 00:59.
//    At 00:00 the count holds and done=1 (level). wrap is never asserted while down=1.
//    done clears on clr, on an adjust that makes the value nonzero, or on down=0. done resets to 0.
//   Undefined: up-count only; ports down and done are absent.
// STRUCTURE
//  Package stopwatch_pkg:
//   state_t enum {ST_RUN, ST_PAUSE, ST_ADJ}
//   constants DEF_SEC_MOD=60, DEF_MIN_MOD=60
//  Sub-module mod_counter (params MOD, STEP), instantiated twice (sec, min):
//   inputs inc1, incs (step), dec1 (countdown only), clr
//   outputs value, carry/borrow
//  FSM, priority logic and wrap/done generation live in the top module.
// TESTING
//  T1 Reset/run: rst_n low mid-count -> outputs 0 immediately. 125 ticks -> 02:05, wrap never 1.
//  T2 Wrap: preload 59:59 via adjust, then one tick -> 00:00 with wrap high exactly 1 cycle.
//  T3 Adjust, ADJ_STEP=2, sel=1: sec=58 + adj_tick -> sec=0, min unchanged. sel=0, min=59 -> min=1.
//  T4 Pause: pse, then 10 ticks -> count unchanged. pse+tick same edge -> dropped. Second pse -> counting resumes.
//  T5 Collisions: clr+tick -> 00:00. In ST_ADJ, tick+adj_tick -> only +ADJ_STEP. adj released while paused -> ST_PAUSE.
//  T6 (COUNTDOWN_EN) down=1 from 01:00, 60 ticks -> 00:00, done=1. Further ticks hold 00:00. clr -> done=0.

Source files
------------

// File: rtl/stopwatch_timebase_pkg.sv
// Shared types and defaults for the MM:SS stopwatch core.
// Optional countdown support is enabled with STOPWATCH_COUNTDOWN_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PAUSE,
    ST_ADJ
  } state_t;

  localparam int unsigned DEF_SEC_MOD = 60;
  localparam int unsigned DEF_MIN_MOD = 60;

endpackage

// File: rtl/stopwatch_timebase_if.sv
// Control strobes in, MM:SS value and flags out.
// Macro STOPWATCH_COUNTDOWN_EN adds the down/done pair.
interface stopwatch_timebase_if
  import stopwatch_pkg::*;
#(
  parameter int unsigned SEC_MOD = DEF_SEC_MOD,
  parameter int unsigned MIN_MOD = DEF_MIN_MOD
);
  localparam int unsigned SEC_W = $clog2(SEC_MOD);
  localparam int unsigned MIN_W = $clog2(MIN_MOD);

  logic             tick;
  logic             adj_tick;
  logic             adj;
  logic             sel;
  logic             pse;
  logic             clr;
  logic [SEC_W-1:0] sec;
  logic [MIN_W-1:0] min;
  logic             paused;
  logic             wrap;
`ifdef STOPWATCH_COUNTDOWN_EN
  logic             down;
  logic             done;
`endif

  modport master (
`ifdef STOPWATCH_COUNTDOWN_EN
    output down,
    input  done,
`endif
    output tick, adj_tick, adj, sel, pse, clr,
    input  sec, min, paused, wrap
  );

  modport slave (
`ifdef STOPWATCH_COUNTDOWN_EN
    input  down,
    output done,
`endif
    input  tick, adj_tick, adj, sel, pse, clr,
    output sec, min, paused, wrap
  );

endinterface

// File: rtl/stopwatch_timebase_mod_counter.sv
// Modulo-MOD counter: +1 with carry, +STEP without carry, -1 with borrow.
// The countdown path (dec1) is tied off unless STOPWATCH_COUNTDOWN_EN is defined.
module mod_counter #(
  parameter  int unsigned MOD  = 60,
  parameter  int unsigned STEP = 1,
  localparam int unsigned W    = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc1,
  input  logic         incs,
  input  logic         dec1,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         carry,
  output logic         borrow
);
  localparam logic [W:0]   MOD_X  = (W+1)'(MOD);
  localparam logic [W:0]   STEP_X = (W+1)'(STEP);
  localparam logic [W-1:0] MAX    = W'(MOD - 1);

  logic [W:0] sum_step;

  // One spare bit so v+STEP never overflows before the modulo compare.
  assign sum_step = {1'b0, value} + STEP_X;
  assign carry    = inc1 && (value == MAX);
  assign borrow   = dec1 && (value == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (incs) begin
      value <= (sum_step >= MOD_X) ? W'(sum_step - MOD_X) : W'(sum_step);
    end else if (inc1) begin
      value <= carry ? '0 : value + 1'b1;
    end else if (dec1) begin
      value <= borrow ? MAX : value - 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_timebase.sv
// MM:SS stopwatch core: run/pause/adjust FSM, priority clr > pse > adjust > tick.
// Macro STOPWATCH_COUNTDOWN_EN adds down-counting with a done level.
module stopwatch_timebase
  import stopwatch_pkg::*;
#(
  parameter int unsigned SEC_MOD  = DEF_SEC_MOD,
  parameter int unsigned MIN_MOD  = DEF_MIN_MOD,
  parameter int unsigned ADJ_STEP = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  stopwatch_timebase_if.slave bus
);
  localparam int unsigned SEC_W = $clog2(SEC_MOD);
  localparam int unsigned MIN_W = $clog2(MIN_MOD);

  state_t state_q, state_n;
  logic   paused_q, paused_n;
  logic   wrap_q, wrap_n;
  logic   run_tick, clr_cnt;
  logic   sec_inc1, sec_incs, sec_dec1, sec_carry, sec_borrow;
  logic   min_inc1, min_incs, min_dec1, min_carry, min_borrow;
  logic   down_mode;

`ifdef STOPWATCH_COUNTDOWN_EN
  logic done_q, done_n;
  logic cnt_zero, sec_adj_zero, min_adj_zero;

  assign down_mode    = bus.down;
  assign cnt_zero     = (bus.sec == '0) && (bus.min == '0);
  assign sec_adj_zero = (32'(bus.sec) + ADJ_STEP) == SEC_MOD;
  assign min_adj_zero = (32'(bus.min) + ADJ_STEP) == MIN_MOD;
  assign sec_dec1     = run_tick && down_mode && !cnt_zero;
  assign min_dec1     = sec_borrow;
  assign bus.done     = done_q;
`else
  assign down_mode = 1'b0;
  assign sec_dec1  = 1'b0;
  assign min_dec1  = 1'b0;
`endif

  assign sec_inc1 = run_tick && !down_mode;
  assign min_inc1 = sec_carry;
  assign wrap_n   = min_carry;

  always_comb begin
    state_n  = state_q;
    paused_n = paused_q;
    run_tick = 1'b0;
    clr_cnt  = 1'b0;
    sec_incs = 1'b0;
    min_incs = 1'b0;
    if (bus.clr) begin
      clr_cnt = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (bus.pse) begin
            paused_n = 1'b1;
            state_n  = ST_PAUSE;
          end else if (bus.adj) begin
            state_n = ST_ADJ;
          end else if (bus.tick) begin
            run_tick = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (bus.pse) begin
            paused_n = 1'b0;
            state_n  = ST_RUN;
          end else if (bus.adj) begin
            state_n = ST_ADJ;
          end
        end
        ST_ADJ: begin
          if (bus.pse) begin
            paused_n = !paused_q;
          end else if (bus.adj_tick) begin
            sec_incs = bus.sel;
            min_incs = !bus.sel;
          end
          // Exit honours a pause toggle taken on the same edge.
          if (!bus.adj) state_n = paused_n ? ST_PAUSE : ST_RUN;
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

`ifdef STOPWATCH_COUNTDOWN_EN
  always_comb begin
    done_n = done_q;
    if (!bus.down || clr_cnt) begin
      done_n = 1'b0;
    end else if (run_tick && (cnt_zero || (bus.min == '0 && bus.sec == SEC_W'(1)))) begin
      done_n = 1'b1;
    end else if (sec_incs && !(sec_adj_zero && bus.min == '0)) begin
      done_n = 1'b0;
    end else if (min_incs && !(min_adj_zero && bus.sec == '0)) begin
      done_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_n;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      paused_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      paused_q <= paused_n;
      wrap_q   <= wrap_n;
    end
  end

  assign bus.paused = paused_q;
  assign bus.wrap   = wrap_q;

  mod_counter #(.MOD(SEC_MOD), .STEP(ADJ_STEP)) u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc1   (sec_inc1),
    .incs   (sec_incs),
    .dec1   (sec_dec1),
    .clr    (clr_cnt),
    .value  (bus.sec),
    .carry  (sec_carry),
    .borrow (sec_borrow)
  );

  mod_counter #(.MOD(MIN_MOD), .STEP(ADJ_STEP)) u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc1   (min_inc1),
    .incs   (min_incs),
    .dec1   (min_dec1),
    .clr    (clr_cnt),
    .value  (bus.min),
    .carry  (min_carry),
    .borrow (min_borrow)
  );

endmodule
